// File: rtl/cycle_fan_driver.sv
// Fan motor driver: spin-up burst, temperature-scaled PWM run, enforced min-on and min-off times.
// Latency: state, duty and PWM follow the inputs one clock later; all outputs decode registers only.
// Backpressure: none; the fan request is a level sampled every clock, ignored in SPINUP and HOLD_OFF.
module cycle_fan_driver #(
    parameter int PWM_BITS       = 4,
    parameter int SPINUP_CYCLES  = 32,
    parameter int MIN_ON_CYCLES  = 64,
    parameter int MIN_OFF_CYCLES = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fan,
    input  logic [2:0]          temperature,
    output logic                fan_pwm,
    output logic                fan_active,
    output logic [1:0]          drive_state,
    output logic [PWM_BITS-1:0] duty
);

    localparam int ON_W  = $clog2(MIN_ON_CYCLES + 1);
    localparam int OFF_W = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;

    localparam logic [ON_W-1:0]  ON_MAX   = ON_W'(MIN_ON_CYCLES);
    localparam logic [ON_W-1:0]  SPIN_END = ON_W'(SPINUP_CYCLES);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(MIN_OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF      = 2'b00,
        S_SPINUP   = 2'b01,
        S_RUN      = 2'b10,
        S_HOLD_OFF = 2'b11
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [ON_W-1:0]     on_cnt;
    logic [ON_W-1:0]     on_cnt_inc;
    logic [OFF_W-1:0]    off_cnt;
    logic [PWM_BITS-1:0] duty_load;
    logic                pwm_wrap;

    // on_cnt_inc is the active-time count as it will read after this edge,
    // so "clocks since SPINUP entry" includes the clock that ends here.
    assign on_cnt_inc = (on_cnt >= ON_MAX) ? ON_MAX : on_cnt + ON_W'(1);
    assign duty_load  = PWM_BITS'({temperature, 1'b1});
    assign pwm_wrap   = (pwm_cnt == {PWM_BITS{1'b1}});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_OFF;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and output decode from registered state.
    always_comb begin
        state_next  = state;
        fan_pwm     = 1'b0;
        fan_active  = 1'b0;
        drive_state = state;
        unique case (state)
            S_OFF: begin
                if (fan) begin
                    state_next = S_SPINUP;
                end
            end
            S_SPINUP: begin
                fan_pwm    = 1'b1;
                fan_active = 1'b1;
                if (on_cnt_inc >= SPIN_END) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                fan_pwm    = (pwm_cnt < duty);
                fan_active = 1'b1;
                if (!fan && (on_cnt_inc >= ON_MAX)) begin
                    state_next = S_HOLD_OFF;
                end
            end
            S_HOLD_OFF: begin
                if (off_cnt == OFF_LAST) begin
                    state_next = S_OFF;
                end
            end
            default: begin
                state_next = S_OFF;
            end
        endcase
    end

    // Free-running PWM phase counter, wraps naturally at 2^PWM_BITS.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Active-time counter: zero while OFF so SPINUP entry starts from 0, saturating while active.
    always_ff @(posedge clk) begin
        if (reset) begin
            on_cnt <= '0;
        end else begin
            unique case (state)
                S_OFF:              on_cnt <= '0;
                S_SPINUP, S_RUN:    on_cnt <= on_cnt_inc;
                default:            on_cnt <= on_cnt;
            endcase
        end
    end

    // Forced-off hold counter, cleared whenever not in HOLD_OFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            off_cnt <= '0;
        end else if (state == S_HOLD_OFF) begin
            off_cnt <= off_cnt + OFF_W'(1);
        end else begin
            off_cnt <= '0;
        end
    end

    // Duty register: loaded on RUN entry and at each PWM wrap while in RUN, zero elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty <= '0;
        end else if (state_next == S_RUN) begin
            if ((state != S_RUN) || pwm_wrap) begin
                duty <= duty_load;
            end
        end else begin
            duty <= '0;
        end
    end

endmodule

// File: doc/cycle_fan_driver.md
CYCLE_FAN_DRIVER -- requirements
Module: cycle_fan_driver

Interface
REQ-001 Parameter PWM_BITS, default 4, SHALL set the PWM counter width; the PWM period is 2^PWM_BITS clocks.
REQ-002 Parameter SPINUP_CYCLES, default 32, SHALL set the full-on spin-up duration in clocks.
REQ-003 Parameter MIN_ON_CYCLES, default 64, SHALL set the minimum active time in clocks, counted from SPINUP entry; MIN_ON_CYCLES >= SPINUP_CYCLES.
REQ-004 Parameter MIN_OFF_CYCLES, default 32, SHALL set the forced-off hold time in clocks.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-007 fan  input  1  SHALL be the fan request from the cooling-system decision stage.
REQ-008 temperature  input  3  SHALL be the temperature level (0-7) that selects RUN duty.
REQ-009 fan_pwm  output  1  SHALL be the fan motor drive.
REQ-010 fan_active  output  1  SHALL be 1 in SPINUP or RUN, else 0.
REQ-011 drive_state  output  2  SHALL expose the FSM state: OFF=00, SPINUP=01, RUN=10, HOLD_OFF=11.
REQ-012 duty  output  PWM_BITS  SHALL expose the registered duty value in use.

Function
REQ-013 All outputs SHALL decode registered state only; no combinational input-to-output path.
REQ-014 pwm_cnt (PWM_BITS) SHALL free-run in every state, +1 per clock, wrapping 2^PWM_BITS-1 -> 0.
REQ-015 OFF: fan_pwm=0, duty=0; fan=1 sampled at an edge SHALL enter SPINUP at that edge and clear on_cnt.
REQ-016 SPINUP: fan_pwm SHALL be 1 continuously for exactly SPINUP_CYCLES clocks, then enter RUN; fan is ignored during SPINUP.
REQ-017 On RUN entry, duty SHALL load {temperature, 1'b1} (PWM_BITS=4: level 0 -> 1, level 7 -> 15).
REQ-018 In RUN, duty SHALL reload {temperature, 1'b1} only on the edge where pwm_cnt wraps to 0; mid-period temperature changes SHALL NOT alter duty.
REQ-019 In RUN, fan_pwm SHALL be 1 when pwm_cnt < duty, else 0.
REQ-020 on_cnt SHALL count clocks from SPINUP entry and saturate at MIN_ON_CYCLES; no wrap.
REQ-021 RUN SHALL exit to HOLD_OFF on the first edge where fan=0 and on_cnt >= MIN_ON_CYCLES; fan=0 earlier SHALL keep RUN.
REQ-022 HOLD_OFF: fan_pwm=0, duty=0; exactly MIN_OFF_CYCLES clocks, then OFF; fan ignored throughout.
REQ-023 From OFF, a fan request held through HOLD_OFF SHALL enter SPINUP on the edge after OFF entry (one OFF clock minimum).
REQ-024 fan_active, drive_state and duty SHALL update on the same edge as the state transition.

Reset
REQ-025 reset=1 at an edge SHALL force OFF, pwm_cnt=0, on_cnt=0, off counter=0, duty=0, fan_pwm=0, fan_active=0, from any state, mid-period included.
REQ-026 reset SHALL take priority over fan; no SPINUP entry at an edge where reset=1.
REQ-027 The first edge with reset=0 and fan=1 SHALL enter SPINUP.

Verification
REQ-028 reset=1 two clocks with fan=1 -> drive_state=00, fan_pwm=0, duty=0; reset released -> drive_state=01 on the next edge.
REQ-029 fan=1 held, temperature=2 -> fan_pwm=1 for 32 clocks, then RUN with duty=5; fan_pwm high 5 of every 16 clocks.
REQ-030 One-clock fan pulse -> SPINUP 32 clocks, RUN until on_cnt=64 (fan_active high 64 clocks total), HOLD_OFF 32 clocks with fan_pwm=0, then OFF.
REQ-031 fan toggled during HOLD_OFF -> no state change; fan=1 held -> 1 OFF clock, then SPINUP.
REQ-032 In RUN, temperature 2 -> 7 at pwm_cnt=6 -> duty stays 5 until pwm_cnt wraps, then duty=15.
REQ-033 reset pulsed in RUN at pwm_cnt=3 -> next edge drive_state=00, fan_pwm=0, pwm_cnt=0, duty=0.
